mem_ctrl: RTL and testbench

//  Arbitrates icache and dcache block requests onto the single main-memory port, one transaction at a time.

---
 rtl/mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates icache/dcache block requests onto main_mem, one transaction at a time; MEM_CTRL_FAIR_EN adds dcache anti-starvation.
// Latency: accept@0, main_mem req@1, cache resp@2+L, next accept@3+L; both caches see ready=0 outside IDLE.
module mem_ctrl #(
  parameter int ADDR_WIDTH       = 32,
  parameter int BLOCK_DATA_WIDTH = 64,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                        clk,
  input  logic                        rst_aL,

  input  logic                        icache_req_valid,
  input  logic [ADDR_WIDTH-4:0]       icache_req_block_addr,
  output logic                        icache_req_ready,
  output logic                        icache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,

  input  logic                        dcache_req_valid,
  input  logic                        dcache_req_type,
  input  logic [ADDR_WIDTH-4:0]       dcache_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data,
  output logic                        dcache_req_ready,
  output logic                        dcache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data,

  output logic                        main_mem_req_valid,
  output logic                        main_mem_req_type,
  output logic [ADDR_WIDTH-4:0]       main_mem_req_block_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] main_mem_req_block_data,
  input  logic                        main_mem_resp_valid,
  input  logic [BLOCK_DATA_WIDTH-1:0] main_mem_resp_block_data
);

  localparam logic REQ_READ  = 1'b0;
  localparam logic OWNER_I   = 1'b0;
  localparam logic OWNER_D   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_owner;
  logic                          r_type;
  logic [ADDR_WIDTH-4:0]         r_addr;
  logic [BLOCK_DATA_WIDTH-1:0]   r_data;

  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;
  logic w_force_d;
  logic w_mem_done;

  assign w_idle     = (r_state == S_IDLE);
  assign w_mem_done = (r_state == S_MEM_WAIT) & main_mem_resp_valid;

`ifdef MEM_CTRL_FAIR_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve_cnt;

  // Forcing only makes sense while dcache is still asking; otherwise icache would stall for nothing.
  assign w_force_d = (r_starve_cnt == CW'(STARVE_LIMIT)) & dcache_req_valid;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d) begin
      r_starve_cnt <= '0;
    end else if (w_grant_i && dcache_req_valid && (r_starve_cnt != CW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end
`else
  assign w_force_d = 1'b0;
`endif

  assign icache_req_ready = w_idle & ~w_force_d;
  assign dcache_req_ready = w_idle & (~icache_req_valid | w_force_d);

  assign w_grant_i = icache_req_valid & icache_req_ready;
  assign w_grant_d = dcache_req_valid & dcache_req_ready;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_grant_i || w_grant_d) w_state_nxt = S_ISSUE;
      S_ISSUE:    w_state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: if (main_mem_resp_valid) w_state_nxt = S_RESP;
      S_RESP:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // On a write the latched block is kept and echoed back; main_mem read data is ignored.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_owner <= OWNER_I;
      r_type  <= REQ_READ;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_grant_i) begin
      r_owner <= OWNER_I;
      r_type  <= REQ_READ;
      r_addr  <= icache_req_block_addr;
      r_data  <= '0;
    end else if (w_grant_d) begin
      r_owner <= OWNER_D;
      r_type  <= dcache_req_type;
      r_addr  <= dcache_req_block_addr;
      r_data  <= dcache_req_block_data;
    end else if (w_mem_done && (r_type == REQ_READ)) begin
      r_data  <= main_mem_resp_block_data;
    end
  end

  always_comb begin
    main_mem_req_valid      = 1'b0;
    main_mem_req_type       = REQ_READ;
    main_mem_req_block_addr = '0;
    main_mem_req_block_data = '0;
    if (r_state == S_ISSUE) begin
      main_mem_req_valid      = 1'b1;
      main_mem_req_type       = r_type;
      main_mem_req_block_addr = r_addr;
      main_mem_req_block_data = r_data;
    end
  end

  always_comb begin
    icache_resp_valid      = 1'b0;
    icache_resp_block_data = '0;
    dcache_resp_valid      = 1'b0;
    dcache_resp_block_data = '0;
    if (r_state == S_RESP) begin
      if (r_owner == OWNER_D) begin
        dcache_resp_valid      = 1'b1;
        dcache_resp_block_data = r_data;
      end else begin
        icache_resp_valid      = 1'b1;
        icache_resp_block_data = r_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected cache responses and main_mem requests; monitors pop and compare.
module tb_mem_ctrl;

  localparam int AW = 29;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_aL;
  logic          icache_req_valid;
  logic [AW-1:0] icache_req_block_addr;
  logic          icache_req_ready;
  logic          icache_resp_valid;
  logic [DW-1:0] icache_resp_block_data;
  logic          dcache_req_valid;
  logic          dcache_req_type;
  logic [AW-1:0] dcache_req_block_addr;
  logic [DW-1:0] dcache_req_block_data;
  logic          dcache_req_ready;
  logic          dcache_resp_valid;
  logic [DW-1:0] dcache_resp_block_data;
  logic          main_mem_req_valid;
  logic          main_mem_req_type;
  logic [AW-1:0] main_mem_req_block_addr;
  logic [DW-1:0] main_mem_req_block_data;
  logic          main_mem_resp_valid;
  logic [DW-1:0] main_mem_resp_block_data;

  mem_ctrl #(.ADDR_WIDTH(32), .BLOCK_DATA_WIDTH(DW), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst_aL(rst_aL),
    .icache_req_valid(icache_req_valid), .icache_req_block_addr(icache_req_block_addr),
    .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
    .icache_resp_block_data(icache_resp_block_data),
    .dcache_req_valid(dcache_req_valid), .dcache_req_type(dcache_req_type),
    .dcache_req_block_addr(dcache_req_block_addr), .dcache_req_block_data(dcache_req_block_data),
    .dcache_req_ready(dcache_req_ready), .dcache_resp_valid(dcache_resp_valid),
    .dcache_resp_block_data(dcache_resp_block_data),
    .main_mem_req_valid(main_mem_req_valid), .main_mem_req_type(main_mem_req_type),
    .main_mem_req_block_addr(main_mem_req_block_addr), .main_mem_req_block_data(main_mem_req_block_data),
    .main_mem_resp_valid(main_mem_resp_valid), .main_mem_resp_block_data(main_mem_resp_block_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic d; logic [DW-1:0] data; } rsp_t;
  typedef struct packed { logic t; logic [AW-1:0] a; logic [DW-1:0] data; } mmr_t;

  rsp_t rsp_q[$];
  mmr_t mm_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int resp_cyc = -1;
  int mm_cyc = -1;
  int mem_lat = 1;
  int mem_cd = 0;
  logic [DW-1:0] mem_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Main memory model: responds mem_lat cycles after each request pulse, whether or not reset intervened.
  initial begin
    main_mem_resp_valid = 1'b0;
    main_mem_resp_block_data = '0;
    forever begin
      @(posedge clk); #1;
      main_mem_resp_valid = 1'b0;
      main_mem_resp_block_data = '0;
      if (mem_cd > 0) begin
        mem_cd--;
        if (mem_cd == 0) begin
          main_mem_resp_valid = 1'b1;
          main_mem_resp_block_data = mem_rdata;
        end
      end
      @(negedge clk);
      if (main_mem_req_valid) mem_cd = mem_lat;
    end
  end

  always @(negedge clk) begin
    if (icache_resp_valid || dcache_resp_valid) begin
      resp_cnt++;
      resp_cyc = cyc;
      if (rsp_q.size() == 0) begin
        chk("unexpected_resp", {62'd0, dcache_resp_valid, icache_resp_valid}, 64'd0);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("resp_owner", {63'd0, dcache_resp_valid}, {63'd0, r.d});
        chk("resp_exclusive", {63'd0, icache_resp_valid & dcache_resp_valid}, 64'd0);
        chk("resp_data", dcache_resp_valid ? dcache_resp_block_data : icache_resp_block_data, r.data);
      end
    end
    if (!icache_resp_valid) chk("i_data_idle_zero", icache_resp_block_data, 64'd0);
    if (!dcache_resp_valid) chk("d_data_idle_zero", dcache_resp_block_data, 64'd0);
  end

  always @(negedge clk) begin
    if (main_mem_req_valid) begin
      mm_cyc = cyc;
      if (mm_q.size() == 0) begin
        chk("unexpected_mm_req", {63'd0, main_mem_req_valid}, 64'd0);
      end else begin
        mmr_t m;
        m = mm_q.pop_front();
        chk("mm_type", {63'd0, main_mem_req_type}, {63'd0, m.t});
        chk("mm_addr", {35'd0, main_mem_req_block_addr}, {35'd0, m.a});
        chk("mm_data", main_mem_req_block_data, m.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic exp_rsp(input logic d, input logic [DW-1:0] data);
    rsp_t r;
    r.d = d; r.data = data;
    rsp_q.push_back(r);
  endtask

  task automatic exp_mm(input logic t, input logic [AW-1:0] a, input logic [DW-1:0] data);
    mmr_t m;
    m.t = t; m.a = a; m.data = data;
    mm_q.push_back(m);
  endtask

  task automatic req_i(input logic [AW-1:0] a, output int acc);
    icache_req_valid = 1'b1;
    icache_req_block_addr = a;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (icache_req_ready) begin acc = cyc; break; end
      tick();
    end
    tick();
    icache_req_valid = 1'b0;
    icache_req_block_addr = '0;
    if (acc < 0) chk("req_i_timeout", 64'd0, 64'd1);
  endtask

  task automatic req_d(input logic t, input logic [AW-1:0] a, input logic [DW-1:0] data, output int acc);
    dcache_req_valid = 1'b1;
    dcache_req_type = t;
    dcache_req_block_addr = a;
    dcache_req_block_data = data;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dcache_req_ready) begin acc = cyc; break; end
      tick();
    end
    tick();
    dcache_req_valid = 1'b0;
    dcache_req_block_addr = '0;
    dcache_req_block_data = '0;
    if (acc < 0) chk("req_d_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 100 && rsp_q.size() != 0; k++) tick();
    chk("drain_done", rsp_q.size(), 64'd0);
    tick();
  endtask

  int c0, c1, n0, ng, d_idx, nacc;
  int acc[2];
  logic dgrant;

  initial begin
    rst_aL = 1'b0;
    icache_req_valid = 1'b0; icache_req_block_addr = '0;
    dcache_req_valid = 1'b0; dcache_req_type = 1'b0;
    dcache_req_block_addr = '0; dcache_req_block_data = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_i_ready", {63'd0, icache_req_ready}, 64'd1);
    chk("rst_mm_valid", {63'd0, main_mem_req_valid}, 64'd0);
    chk("rst_mm_addr", {35'd0, main_mem_req_block_addr}, 64'd0);
    chk("rst_mm_data", main_mem_req_block_data, 64'd0);
    chk("rst_resp_valids", {62'd0, icache_resp_valid, dcache_resp_valid}, 64'd0);
    tick();
    rst_aL = 1'b1;
    tick();

    // 1: icache read, L=3
    mem_lat = 3; mem_rdata = 64'hDEADBEEF_CAFEF00D;
    exp_mm(1'b0, 29'h10, 64'd0);
    exp_rsp(1'b0, 64'hDEADBEEF_CAFEF00D);
    n0 = resp_cnt;
    req_i(29'h10, c0);
    drain();
    chk("t1_mm_req_cycle", mm_cyc - c0, 64'd1);
    chk("t1_resp_cycle", resp_cyc - c0, 64'd5);
    chk("t1_resp_count", resp_cnt - n0, 64'd1);

    // 2: simultaneous icache and dcache, L=2
    mem_lat = 2; mem_rdata = 64'h01234567_89ABCDEF;
    exp_mm(1'b0, 29'h44, 64'd0);
    exp_rsp(1'b0, 64'h01234567_89ABCDEF);
    exp_mm(1'b0, 29'h88, 64'd0);
    exp_rsp(1'b1, 64'h01234567_89ABCDEF);
    icache_req_valid = 1'b1; icache_req_block_addr = 29'h44;
    dcache_req_valid = 1'b1; dcache_req_type = 1'b0;
    dcache_req_block_addr = 29'h88; dcache_req_block_data = '0;
    @(negedge clk);
    chk("t2_i_ready", {63'd0, icache_req_ready}, 64'd1);
    chk("t2_d_ready_blocked", {63'd0, dcache_req_ready}, 64'd0);
    c0 = cyc;
    tick();
    icache_req_valid = 1'b0; icache_req_block_addr = '0;
    c1 = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dcache_req_ready) begin c1 = cyc; break; end
      tick();
    end
    tick();
    dcache_req_valid = 1'b0; dcache_req_block_addr = '0;
    chk("t2_d_accept_cycle", c1 - c0, 64'd5);
    drain();

    // 3: dcache write, main_mem returns 0
    mem_lat = 2; mem_rdata = 64'd0;
    exp_mm(1'b1, 29'h20, 64'h11223344_55667788);
    exp_rsp(1'b1, 64'h11223344_55667788);
    req_d(1'b1, 29'h20, 64'h11223344_55667788, c0);
    drain();
    chk("t3_resp_cycle", resp_cyc - c0, 64'd4);

    // 4: reset during MEM_WAIT, stray response afterwards
    mem_lat = 5; mem_rdata = 64'hBAD0BAD0_BAD0BAD0;
    exp_mm(1'b0, 29'h30, 64'd0);
    n0 = resp_cnt;
    req_i(29'h30, c0);
    tick();
    rst_aL = 1'b0;
    @(negedge clk);
    chk("t4_rst_mm_valid", {63'd0, main_mem_req_valid}, 64'd0);
    chk("t4_rst_resp_valids", {62'd0, icache_resp_valid, dcache_resp_valid}, 64'd0);
    chk("t4_rst_i_ready", {63'd0, icache_req_ready}, 64'd1);
    chk("t4_rst_d_ready", {63'd0, dcache_req_ready}, 64'd1);
    tick();
    rst_aL = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("t4_no_resp_after_reset", resp_cnt - n0, 64'd0);
    @(negedge clk);
    chk("t4_idle_after_stray", {63'd0, icache_req_ready}, 64'd1);
    tick();

    // 5: icache valid every cycle with a dcache read pending
    mem_lat = 1; mem_rdata = 64'hFEEDFACE_0BADC0DE;
    icache_req_valid = 1'b1; icache_req_block_addr = 29'hA5;
    dcache_req_valid = 1'b1; dcache_req_type = 1'b0;
    dcache_req_block_addr = 29'hD5; dcache_req_block_data = '0;
    ng = 0; d_idx = -1;
    for (int k = 0; k < 80 && ng < 4; k++) begin
      dgrant = 1'b0;
      @(negedge clk);
      if (icache_req_valid && icache_req_ready) begin
        exp_mm(1'b0, 29'hA5, 64'd0); exp_rsp(1'b0, 64'hFEEDFACE_0BADC0DE); ng++;
      end else if (dcache_req_valid && dcache_req_ready) begin
        exp_mm(1'b0, 29'hD5, 64'd0); exp_rsp(1'b1, 64'hFEEDFACE_0BADC0DE);
        d_idx = ng; ng++; dgrant = 1'b1;
      end
      tick();
      if (dgrant) dcache_req_valid = 1'b0;
    end
    icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
    chk("t5_grant_count", ng, 64'd4);
`ifdef MEM_CTRL_FAIR_EN
    chk("t5_d_grant_index", d_idx, 64'd2);
`else
    chk("t5_d_never_granted", d_idx, -64'sd1);
`endif
    drain();

    // 6: icache valid held through RESP
    mem_lat = 2; mem_rdata = 64'h55AA55AA_AA55AA55;
    icache_req_valid = 1'b1; icache_req_block_addr = 29'h60;
    nacc = 0; acc[0] = -100; acc[1] = -100;
    for (int k = 0; k < 40 && nacc < 2; k++) begin
      @(negedge clk);
      if (nacc == 1 && cyc == acc[0] + 4) begin
        chk("t6_resp_in_resp", {63'd0, icache_resp_valid}, 64'd1);
        chk("t6_ready_in_resp", {63'd0, icache_req_ready}, 64'd0);
      end
      if (icache_req_ready) begin
        acc[nacc] = cyc;
        exp_mm(1'b0, 29'h60, 64'd0); exp_rsp(1'b0, 64'h55AA55AA_AA55AA55);
        nacc++;
      end
      tick();
    end
    icache_req_valid = 1'b0;
    chk("t6_reaccept_cycle", acc[1] - acc[0], 64'd5);
    drain();

    chk("mm_q_drained", mm_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
